// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the 4-way memory port arbiter: state encoding,
// requester count/selector width and a one-hot helper.
package mem_port_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick_4.sv
// Combinational round-robin picker: first set request bit searching from ptr_i
// upward (mod 4).
module rr_pick_4
    import mem_port_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic               any_o,
    output logic [SEL_W-1:0]   idx_o
);

    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   off;

    // rot[k] is the request at search position k, i.e. requester ptr+k (wrapping)
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            localparam logic [SEL_W-1:0] OFF = SEL_W'(gi);
            assign rot[gi] = req_i[ptr_i + OFF];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = SEL_W'(k);
            end
        end
    end

    assign idx_o = ptr_i + off;
    assign any_o = |req_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port among four requesters;
// one transaction at a time, per-owner completion pulse, abort on timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TMR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               mem_done_i,
    output logic [SEL_W-1:0]   selection_o,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               mem_start_o,
    output logic [NUM_REQ-1:0] done_o,
    output logic               timeout_err_o,
    output logic               busy_o
);

    state_e             state_q;
    logic [SEL_W-1:0]   selection_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [SEL_W-1:0]   ptr_d;
    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   timer_d;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic               mem_start_q;
    logic               timeout_err_q;
    logic               busy_q;

    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic               timeout_hit;

    rr_pick_4 u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // selection_q doubles as the owner index; it only changes on the IDLE->ISSUE edge
    assign ptr_d       = selection_q + 1'b1;
    assign timer_d     = timer_q + 1'b1;
    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            selection_q   <= '0;
            ptr_q         <= '0;
            timer_q       <= '0;
            grant_q       <= '0;
            done_q        <= '0;
            mem_start_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            mem_start_q   <= 1'b0;
            done_q        <= '0;
            timeout_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        selection_q <= pick_idx;
                        grant_q     <= onehot(pick_idx);
                        mem_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // MemDone on the final allowed cycle still counts as success
                    if (mem_done_i) begin
                        done_q  <= onehot(selection_q);
                        state_q <= ST_DONE;
                    end else if (timeout_hit) begin
                        done_q        <= onehot(selection_q);
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_DONE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                ST_DONE: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= ptr_d;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign selection_o   = selection_q;
    assign grant_o       = grant_q;
    assign mem_start_o   = mem_start_q;
    assign done_o        = done_q;
    assign timeout_err_o = timeout_err_q;
    assign busy_o        = busy_q;

endmodule
